// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment frame capture: active-low glyph patterns,
// FSM state encoding and small an_n helpers.
package seg7_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } seg7_state_t;

  function automatic logic is_onehot_low(input logic [3:0] an_n);
    case (an_n)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] digit_index(input logic [3:0] an_n);
    case (an_n)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// Display-side inputs and captured-frame outputs of seg7_capture.
// master = display/stimulus side, slave = capture block.
interface seg7_capture_if;
  import seg7_pkg::*;

  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  digit_err;
  logic [3:0]  digit_blank;

  modport master (
    output seg_n, an_n,
    input  value, frame_valid, digit_err, digit_blank
  );

  modport slave (
    input  seg_n, an_n,
    output value, frame_valid, digit_err, digit_blank
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: maps an active-low segment pattern to a hex nibble.
// o_known marks a hex glyph; o_blank marks all segments off; neither means unrecognised.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg_n,
  output logic [3:0] o_nibble,
  output logic       o_known,
  output logic       o_blank
);

  always_comb begin
    o_nibble = 4'h0;
    o_known  = 1'b1;
    o_blank  = 1'b0;
    case (i_seg_n)
      SEG_0:     o_nibble = 4'h0;
      SEG_1:     o_nibble = 4'h1;
      SEG_2:     o_nibble = 4'h2;
      SEG_3:     o_nibble = 4'h3;
      SEG_4:     o_nibble = 4'h4;
      SEG_5:     o_nibble = 4'h5;
      SEG_6:     o_nibble = 4'h6;
      SEG_7:     o_nibble = 4'h7;
      SEG_8:     o_nibble = 4'h8;
      SEG_9:     o_nibble = 4'h9;
      SEG_A:     o_nibble = 4'hA;
      SEG_B:     o_nibble = 4'hB;
      SEG_C:     o_nibble = 4'hC;
      SEG_D:     o_nibble = 4'hD;
      SEG_E:     o_nibble = 4'hE;
      SEG_F:     o_nibble = 4'hF;
      SEG_BLANK: begin
        o_known = 1'b0;
        o_blank = 1'b1;
      end
      default:   o_known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Snoops a multiplexed 4-digit display and rebuilds the shown hex value; frame_valid
// follows the completing digit by STABLE_CYCLES+2 cycles. Passive listener, no backpressure.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
)(
  input logic           clk,
  input logic           rst,
  seg7_capture_if.slave bus
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  logic [6:0]  r_seg_smp;
  logic [3:0]  r_an_smp;
  logic [6:0]  r_seg_rec;
  logic [3:0]  r_an_rec;
  seg7_state_t r_state;
  logic [7:0]  r_count;
  logic [15:0] r_slots;
  logic [3:0]  r_seen;
  logic [15:0] r_value;
  logic        r_frame_valid;
  logic [3:0]  r_digit_err;
  logic [3:0]  r_digit_blank;

  seg7_state_t w_state_nxt;
  logic [7:0]  w_count_nxt;
  logic [7:0]  w_count_inc;
  logic        w_same;
  logic        w_onehot;
  logic        w_restart;
  logic        w_record;
  logic        w_capture;
  logic [1:0]  w_idx;
  logic [3:0]  w_bit;
  logic [3:0]  w_dec_nibble;
  logic        w_dec_known;
  logic        w_dec_blank;
  logic        w_frame_done;
  logic [3:0]  w_seen_base;
  logic [3:0]  w_err_base;

  seg7_pattern_decode u_decode (
    .i_seg_n  (r_seg_smp),
    .o_nibble (w_dec_nibble),
    .o_known  (w_dec_known),
    .o_blank  (w_dec_blank)
  );

  assign w_same       = (r_seg_smp == r_seg_rec) && (r_an_smp == r_an_rec);
  assign w_onehot     = is_onehot_low(r_an_smp);
  assign w_count_inc  = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
  assign w_idx        = digit_index(r_an_smp);
  assign w_bit        = ~r_an_smp;
  assign w_frame_done = (r_seen == 4'hF);
  // A capture landing on the completion edge starts the next frame
  assign w_seen_base  = w_frame_done ? 4'h0 : r_seen;
  assign w_err_base   = w_frame_done ? 4'h0 : r_digit_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_restart   = 1'b0;
    w_record    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: w_restart = 1'b1;
      ST_COUNT: begin
        if (w_same) begin
          w_count_nxt = w_count_inc;
          if (w_count_inc >= STABLE_W) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HELD;
          end
        end else begin
          w_restart = 1'b1;
        end
      end
      ST_HELD: if (!w_same) w_restart = 1'b1;
      default: w_state_nxt = ST_IDLE;
    endcase
    // HELD leaving on a changed sample acts exactly like IDLE in the same cycle
    if (w_restart) begin
      if (w_onehot) begin
        w_record    = 1'b1;
        w_count_nxt = 8'd1;
        if (STABLE_W <= 8'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HELD;
        end else begin
          w_state_nxt = ST_COUNT;
        end
      end else begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_smp <= 7'h7F;
      r_an_smp  <= 4'hF;
      r_seg_rec <= 7'h7F;
      r_an_rec  <= 4'hF;
    end else begin
      r_seg_smp <= bus.seg_n;
      r_an_smp  <= bus.an_n;
      if (w_record) begin
        r_seg_rec <= r_seg_smp;
        r_an_rec  <= r_an_smp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slots       <= 16'h0000;
      r_seen        <= 4'h0;
      r_digit_err   <= 4'h0;
      r_digit_blank <= 4'hF;
    end else begin
      r_seen      <= w_seen_base | (w_capture ? w_bit : 4'h0);
      r_digit_err <= w_err_base |
                     ((w_capture && !w_dec_known && !w_dec_blank) ? w_bit : 4'h0);
      if (w_capture && w_dec_known) begin
        r_slots[{w_idx, 2'b00} +: 4] <= w_dec_nibble;
        r_digit_blank                <= r_digit_blank & ~w_bit;
      end else if (w_capture && w_dec_blank) begin
        r_slots[{w_idx, 2'b00} +: 4] <= 4'h0;
        r_digit_blank                <= r_digit_blank | w_bit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value       <= 16'h0000;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_done;
      if (w_frame_done) r_value <= r_slots;
    end
  end

  assign bus.value       = r_value;
  assign bus.frame_valid = r_frame_valid;
  assign bus.digit_err   = r_digit_err;
  assign bus.digit_blank = r_digit_blank;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with STABLE_CYCLES=4; frame_valid pulses are
// counted on the falling edge and expected values are written out by hand.
module tb_seg7_capture;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   fv_count = 0;

  seg7_capture_if bus ();

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_count++;

  function automatic logic [6:0] pat(input int n);
    case (n)
      0:  return 7'h40;  1:  return 7'h79;  2:  return 7'h24;  3:  return 7'h30;
      4:  return 7'h19;  5:  return 7'h12;  6:  return 7'h02;  7:  return 7'h78;
      8:  return 7'h00;  9:  return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    bus.an_n  = ~(4'b0001 << d);
    bus.seg_n = s;
    tick(n);
  endtask

  task automatic gap(input int n);
    bus.an_n  = 4'hF;
    bus.seg_n = 7'h7F;
    tick(n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    gap(3);
    rst = 1'b0;
    tick(1);
    checks++; if (bus.value !== 16'h0000) begin errors++; $display("FAIL reset_value got=%h exp=0000", bus.value); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
    checks++; if (bus.digit_err !== 4'h0) begin errors++; $display("FAIL reset_err got=%b exp=0000", bus.digit_err); end
    checks++; if (bus.digit_blank !== 4'hF) begin errors++; $display("FAIL reset_blank got=%b exp=1111", bus.digit_blank); end
  endtask

  task automatic test_basic;
    int fv0;
    fv0 = fv_count;
    show(3, pat(1), 6); show(2, pat(2), 6); show(1, pat(3), 6); show(0, pat(4), 6);
    gap(4);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL basic_fv got=%0d exp=1", fv_count - fv0); end
    checks++; if (bus.value !== 16'h1234) begin errors++; $display("FAIL basic_value got=%h exp=1234", bus.value); end
    checks++; if (bus.digit_err !== 4'h0) begin errors++; $display("FAIL basic_err got=%b exp=0000", bus.digit_err); end
    checks++; if (bus.digit_blank !== 4'h0) begin errors++; $display("FAIL basic_blank got=%b exp=0000", bus.digit_blank); end
  endtask

  task automatic test_latency;
    int lat;
    show(3, pat(9), 6); show(2, pat(8), 6); show(1, pat(7), 6);
    gap(3);
    bus.an_n  = 4'b1110;
    bus.seg_n = pat(6);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      lat++;
      if (bus.frame_valid === 1'b1) break;
    end
    checks++; if (lat !== 6) begin errors++; $display("FAIL latency got=%0d exp=6", lat); end
    gap(3);
    checks++; if (bus.value !== 16'h9876) begin errors++; $display("FAIL latency_value got=%h exp=9876", bus.value); end
  endtask

  task automatic test_blank;
    int fv0;
    fv0 = fv_count;
    show(3, pat(10), 6); show(2, pat(11), 6); show(1, pat(12), 6); show(0, 7'h7F, 6);
    gap(4);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL blank_fv got=%0d exp=1", fv_count - fv0); end
    checks++; if (bus.value !== 16'hABC0) begin errors++; $display("FAIL blank_value got=%h exp=ABC0", bus.value); end
    checks++; if (bus.digit_blank !== 4'b0001) begin errors++; $display("FAIL blank_flags got=%b exp=0001", bus.digit_blank); end
  endtask

  task automatic test_err;
    int fv0;
    fv0 = fv_count;
    show(3, pat(1), 6); show(2, 7'h55, 6);
    checks++; if (bus.digit_err !== 4'b0100) begin errors++; $display("FAIL err_flag got=%b exp=0100", bus.digit_err); end
    show(1, pat(2), 6); show(0, pat(3), 6);
    gap(4);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL err_fv got=%0d exp=1", fv_count - fv0); end
    checks++; if (bus.value !== 16'h1B23) begin errors++; $display("FAIL err_value got=%h exp=1B23", bus.value); end
    checks++; if (bus.digit_err !== 4'h0) begin errors++; $display("FAIL err_cleared got=%b exp=0000", bus.digit_err); end
  endtask

  task automatic test_short;
    int fv0;
    fv0 = fv_count;
    show(3, pat(15), 3);
    show(2, pat(4), 6); show(1, pat(5), 6); show(0, pat(6), 6);
    gap(5);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL short_hold_fv got=%0d exp=0", fv_count - fv0); end
    for (int i = 0; i < 10; i++) show(3, (i % 2 == 0) ? pat(8) : pat(9), 2);
    gap(5);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL glitch_fv got=%0d exp=0", fv_count - fv0); end
    show(3, pat(7), 6);
    gap(4);
    checks++; if (bus.value !== 16'h7456) begin errors++; $display("FAIL short_value got=%h exp=7456", bus.value); end
  endtask

  task automatic test_long;
    int fv0;
    fv0 = fv_count;
    show(3, pat(14), 50); show(2, pat(13), 6); show(1, pat(0), 6);
    bus.an_n  = 4'b0011;
    bus.seg_n = pat(8);
    tick(10);
    gap(5);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL multi_low_fv got=%0d exp=0", fv_count - fv0); end
    show(0, pat(1), 6);
    gap(4);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL long_fv got=%0d exp=1", fv_count - fv0); end
    checks++; if (bus.value !== 16'hED01) begin errors++; $display("FAIL long_value got=%h exp=ED01", bus.value); end
  endtask

  task automatic test_reset_mid;
    int fv0;
    fv0 = fv_count;
    show(3, pat(5), 6); show(2, pat(5), 6); show(1, pat(5), 6); show(0, pat(5), 2);
    rst = 1'b1;
    gap(2);
    rst = 1'b0;
    tick(1);
    checks++; if (bus.value !== 16'h0000) begin errors++; $display("FAIL rstmid_value got=%h exp=0000", bus.value); end
    checks++; if (bus.digit_blank !== 4'hF) begin errors++; $display("FAIL rstmid_blank got=%b exp=1111", bus.digit_blank); end
    show(0, pat(5), 6);
    gap(5);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL rstmid_partial_fv got=%0d exp=0", fv_count - fv0); end
    show(1, pat(5), 6); show(2, pat(5), 6); show(3, pat(5), 6);
    gap(4);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL rstmid_fv got=%0d exp=1", fv_count - fv0); end
    checks++; if (bus.value !== 16'h5555) begin errors++; $display("FAIL rstmid_value2 got=%h exp=5555", bus.value); end
  endtask

  initial begin
    bus.an_n  = 4'hF;
    bus.seg_n = 7'h7F;
    test_reset;
    test_basic;
    test_latency;
    test_blank;
    test_err;
    test_short;
    test_long;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples needed to accept a digit (legal 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port seg_n  input  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-005 SHALL have port an_n  input  4  active-low digit enables of a multiplexed display, bit i = digit i (digit 3 most significant).
REQ-006 SHALL have port value  output  16  last complete frame, digit i in value[4i+3:4i].
REQ-007 SHALL have port frame_valid  output  1  one-cycle pulse when value updates.
REQ-008 SHALL have port digit_err  output  4  sticky per-digit unrecognised-pattern flag for the current frame.
REQ-009 SHALL have port digit_blank  output  4  per-digit flag indicating the last capture was all segments off.

Function
REQ-010 SHALL register seg_n and an_n once on input before any comparison (one sample stage).
REQ-011 SHALL decode these patterns (hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; blank=7F.
REQ-012 SHALL treat any other pattern as unrecognised.
REQ-013 SHALL implement FSM states IDLE, COUNT, HELD.
REQ-014 IDLE: when sampled an_n is one-hot-low, SHALL go to COUNT with count=1 and record the sample (an_n, seg_n).
REQ-015 COUNT: if the sample equals the recorded one, count SHALL increment; at count==STABLE_CYCLES it SHALL capture and go to HELD.
REQ-016 COUNT: if the sample differs but an_n is still one-hot, SHALL re-record and restart at count=1; if an_n is not one-hot, SHALL go to IDLE.
REQ-017 HELD: SHALL stay until the sample differs from the recorded one, then SHALL behave as IDLE on that same cycle (at most one capture per stable assertion).
REQ-018 With STABLE_CYCLES=1, capture SHALL occur in the cycle the first one-hot sample is seen (IDLE to HELD directly).
REQ-019 Capture of a recognised digit SHALL write its nibble into slot i, set seen[i], clear digit_blank[i].
REQ-020 Capture of blank SHALL write 0 into slot i, set seen[i] and digit_blank[i].
REQ-021 Capture of unrecognised SHALL set digit_err[i] and seen[i], and leave slot i unchanged.
REQ-022 Re-capture of digit i before frame completion SHALL overwrite slot i (last wins).
REQ-023 When seen becomes 4'b1111, SHALL on the next edge copy slots to value, pulse frame_valid for exactly one cycle, and clear seen and digit_err.
REQ-024 Latency: frame_valid SHALL assert STABLE_CYCLES+2 cycles after the raw input for the completing digit first appears.
REQ-025 an_n all-high (blanking gap) or multi-low SHALL never capture and SHALL not disturb seen or slots.
REQ-026 A capture that coincides with frame completion SHALL belong to the next frame (seen cleared, then that bit set).

Reset
REQ-027 On rst: FSM=IDLE, count=0, sample and record registers=all-ones, slots=0, seen=0, value=16'h0000, frame_valid=0, digit_err=0, digit_blank=4'hF.
REQ-028 Reset asserted mid-COUNT or mid-frame SHALL discard partial data; no frame_valid SHALL be produced after reset release until four new captures occur.

Structure
REQ-029 Package seg7_pkg SHALL hold the 16 pattern constants, SEG_BLANK=7'h7F, FSM state type, and STABLE_CYCLES default.
REQ-030 Sub-module seg7_pattern_decode (combinational: seg_n in; nibble, known, blank out) SHALL be instantiated once.
REQ-031 Counter width SHALL be 8 bits and saturate, never wrap.

Verification
REQ-032 Scan digits 3..0 with 1,2,3,4 each held 6 cycles (STABLE_CYCLES=4) -> one frame_valid, value=16'h1234, digit_err=0.
REQ-033 Digit 0 shows 7'h7F, others A,b,C -> value=16'hABC0, digit_blank=4'b0001.
REQ-034 Digit 2 shows 7'h55 -> digit_err[2]=1, value[11:8] keeps the prior frame's nibble, flag cleared after frame_valid.
REQ-035 Digit held only 3 cycles, or seg_n glitching every 2 cycles -> no capture, no frame_valid.
REQ-036 Digit held 50 cycles -> exactly one capture; an_n=4'b0011 for 10 cycles -> no capture.
REQ-037 rst pulsed after digits 3..1 captured, then 0..3 rescanned with 5 -> single frame_valid, value=16'h5555.
